vector_regfile: RTL and testbench
=================================

Name: vector_regfile

Overview:
- Vector register file with a per-register scoreboard. It sits directly upstream of vectorial_alu.
- It provides the two 128-bit operands A and B.
- It accepts the ALU Result for writeback.
- It raises a stall when a source register is still awaiting writeback.
- Scalar mode updates only lane 0 (bits 31:0), which matches the scalar convention of vectorial_alu.

Parameters:
- NUM_REGS, 16, number of 128-bit vector registers (v0..v15); v0 reads as zero.
- DATA_W, 128, register width; four lanes.
- LANE_W, 32, lane width; DATA_W/LANE_W = 4 lanes.
- AW, 4, register address width, equal to clog2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ra1  input  AW  read address for operand A.
- ra2  input  AW  read address for operand B.
- rd1  output  DATA_W  operand A, which feeds vectorial_alu.A.
- rd2  output  DATA_W  operand B, which feeds vectorial_alu.B.
- we  input  1  writeback enable.
- wa  input  AW  writeback address.
- wd  input  DATA_W  writeback data, which is vectorial_alu.Result.
- vectorial  input  1  writeback mode: 1 = vector, 0 = scalar (lane 0 only).
- lane_mask  input  4  per-lane write enable in vector mode; bit i covers bits 32i+31:32i.
- issue_valid  input  1  an instruction using ra1/ra2 and producing issue_rd requests issue.
- issue_rd  input  AW  destination register of the issuing instruction.
- stall  output  1  the issue is blocked by a pending source.
- pending  output  NUM_REGS  scoreboard bit vector, for debug and verification.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All registers are cleared to 0.
  - pending is cleared to 0.
  - All writes and issues in that cycle are ignored.
  - rd1/rd2 therefore read 0 and stall reads 0 in the following cycle.
  - This holds even if reset arrives mid-operation.
- Reads are combinational, with zero read latency.
  - rd1 = v[ra1] and rd2 = v[ra2].
  - v0 always reads 0, and writes to v0 are discarded.
- Write-through bypass:
  - Applies when we=1, wa==raN and wa!=0.
  - rdN then returns the merged value that will be stored at the next edge, as defined by the write rules below.
- Write rules (we=1, wa!=0), applied at the rising edge:
  - vectorial=1: lane i is updated from wd only if lane_mask[i]=1; other lanes hold their value.
  - vectorial=0: only lane 0 is updated from wd[31:0]; lanes 1..3 hold; lane_mask is ignored.
  - we=1 with lane_mask=0 in vector mode writes no data but still clears pending[wa].
- Scoreboard:
  - Combinational hazard terms:
    - hzN = pending[raN] & ~(we & wa==raN).
    - A source being written back in this cycle is not a hazard, because the bypass covers it.
  - stall = issue_valid & (hz1 | hz2); a source of v0 never causes a hazard.
  - Issue accepted (issue_valid & ~stall & issue_rd!=0): pending[issue_rd] is set at the next edge.
  - Writeback (we & wa!=0): pending[wa] is cleared at the next edge.
  - Simultaneous accepted issue and writeback to the same register: the set wins and pending stays 1, because the new producer is outstanding.
  - A stalled issue changes nothing; upstream must hold issue_valid, ra1, ra2 and issue_rd until stall=0.
  - pending[0] is constantly 0.
- Boundary conditions:
  - Writing a register that is not pending is legal.
  - Issuing to an already-pending destination is legal, with no WAW check; pending simply stays set.
  - ra1==ra2 is legal; both outputs are identical.

Test Plan:
- Reset then read: assert rst for 1 cycle, read any register -> rd1=rd2=0, pending=0, stall=0.
- Vector write: we=1, wa=3, vectorial=1, lane_mask=4'b1111, wd=128'h00000005_00000006_00000007_00000008.
  - Next cycle, ra1=3 -> rd1=128'h00000005_00000006_00000007_00000008.
- Masked and scalar merge:
  - Start from v3 above, apply vectorial=1, lane_mask=4'b0101, wd=128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> v3=128'h00000005_BBBBBBBB_00000007_DDDDDDDD.
  - Then apply vectorial=0, wd=128'h...0000000A -> v3=128'h00000005_BBBBBBBB_00000007_0000000A.
- v0 and bypass:
  - we=1, wa=0, wd=all-Fs -> ra1=0 still reads 0.
  - Same-cycle write of wa=5, wd=128'h...14 with ra2=5 -> rd2=128'h...14 in that cycle.
- Hazard:
  - Issue with issue_rd=4 -> pending[4]=1.
  - Next issue_valid with ra1=4 -> stall=1, and pending holds.
  - Writeback we=1, wa=4 in the same cycle -> stall=0 combinationally.
  - Following cycle -> pending[4]=0.
- Set-wins and mid-op reset:
  - Accepted issue with issue_rd=6 and writeback with wa=6 in the same cycle -> pending[6]=1.
  - Then rst=1 while pending=16'h0050 and we=1 -> pending=0 and all registers 0 next cycle.

Source files
------------

// File: rtl/vector_regfile_if.sv
// Operand read, ALU writeback and issue/scoreboard signals between the issue stage and vector_regfile.
// master = issue stage / writeback source, slave = register file.
interface vector_regfile_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 128,
    parameter int LANE_W   = 32,
    parameter int AW       = 4
);
    localparam int LANES = DATA_W / LANE_W;

    logic [AW-1:0]       ra1;
    logic [AW-1:0]       ra2;
    logic [DATA_W-1:0]   rd1;
    logic [DATA_W-1:0]   rd2;
    logic                we;
    logic [AW-1:0]       wa;
    logic [DATA_W-1:0]   wd;
    logic                vectorial;
    logic [LANES-1:0]    lane_mask;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                stall;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output ra1, ra2, we, wa, wd, vectorial, lane_mask, issue_valid, issue_rd,
        input  rd1, rd2, stall, pending
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, vectorial, lane_mask, issue_valid, issue_rd,
        output rd1, rd2, stall, pending
    );
endinterface

// File: rtl/vector_regfile.sv
// Purpose: 16x128b vector register file (v0 = 0) with lane-masked writeback and a per-register pending scoreboard.
// Latency: reads and stall are combinational with write-through bypass; writes and scoreboard updates land at the next edge.
// Backpressure: stall holds off issue while a source awaits writeback; a stalled issue has no side effects.
module vector_regfile #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 128,
    parameter int LANE_W   = 32,
    parameter int AW       = 4
) (
    input logic              clk,
    input logic              rst,
    vector_regfile_if.slave  bus
);
    localparam int LANES = DATA_W / LANE_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_nxt;
    logic                wr_en;
    logic [LANES-1:0]    lane_we;
    logic [DATA_W-1:0]   wmerge;
    logic                hz1;
    logic                hz2;
    logic                stall_c;
    logic                issue_acc;

    // Merged value that will be stored at the next edge; also the bypass value.
    always_comb begin
        wr_en  = bus.we && (bus.wa != '0);
        wmerge = regs[bus.wa];
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = bus.vectorial ? bus.lane_mask[i] : (i == 0);
            if (lane_we[i])
                wmerge[i*LANE_W +: LANE_W] = bus.wd[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        bus.rd1 = regs[bus.ra1];
        bus.rd2 = regs[bus.ra2];
        if (wr_en && (bus.wa == bus.ra1))
            bus.rd1 = wmerge;
        if (wr_en && (bus.wa == bus.ra2))
            bus.rd2 = wmerge;
        if (bus.ra1 == '0)
            bus.rd1 = '0;
        if (bus.ra2 == '0)
            bus.rd2 = '0;
    end

    // A source being written back this cycle is covered by the bypass, so it is not a hazard.
    always_comb begin
        hz1       = pend[bus.ra1] & ~(bus.we & (bus.wa == bus.ra1));
        hz2       = pend[bus.ra2] & ~(bus.we & (bus.wa == bus.ra2));
        stall_c   = bus.issue_valid & (hz1 | hz2);
        issue_acc = bus.issue_valid & ~stall_c & (bus.issue_rd != '0);

        pend_nxt = pend;
        if (wr_en)
            pend_nxt[bus.wa] = 1'b0;
        // Set after clear: a new producer issued alongside the old writeback stays outstanding.
        if (issue_acc)
            pend_nxt[bus.issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;

        bus.stall   = stall_c;
        bus.pending = pend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            pend <= '0;
        end else begin
            if (wr_en)
                regs[bus.wa] <= wmerge;
            pend <= pend_nxt;
        end
    end
endmodule

// File: tb/tb_vector_regfile.sv
// Directed self-checking bench for vector_regfile: reads, lane merge, v0, bypass, scoreboard, mid-op reset.
module tb_vector_regfile;
    logic clk;
    logic rst;
    int   n_asrt;
    int   n_fail;

    vector_regfile_if #(.NUM_REGS(16), .DATA_W(128), .LANE_W(32), .AW(4)) bus ();

    vector_regfile #(.NUM_REGS(16), .DATA_W(128), .LANE_W(32), .AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Commit the current inputs at the next rising edge, then return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we          = 1'b0;
        bus.wa          = '0;
        bus.wd          = '0;
        bus.vectorial   = 1'b1;
        bus.lane_mask   = 4'b0000;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;
        bus.ra1 = '0;
        bus.ra2 = '0;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset state
        bus.ra1 = 4'd3;
        bus.ra2 = 4'd7;
        #1;
        chk("reset_rd1", bus.rd1, 128'h0);
        chk("reset_rd2", bus.rd2, 128'h0);
        chk("reset_pending", {112'h0, bus.pending}, 128'h0);
        chk("reset_stall", {127'h0, bus.stall}, 128'h0);

        // Full vector write with same-cycle bypass, then registered read with ra1==ra2
        bus.we = 1'b1; bus.wa = 4'd3; bus.vectorial = 1'b1; bus.lane_mask = 4'b1111;
        bus.wd = 128'h00000005_00000006_00000007_00000008;
        #1;
        chk("vec_bypass_rd1", bus.rd1, 128'h00000005_00000006_00000007_00000008);
        tick();
        idle();
        bus.ra2 = 4'd3;
        #1;
        chk("vec_write_rd1", bus.rd1, 128'h00000005_00000006_00000007_00000008);
        chk("same_addr_rd2", bus.rd2, 128'h00000005_00000006_00000007_00000008);

        // Lane-masked merge: lanes 0 and 2 only
        bus.we = 1'b1; bus.wa = 4'd3; bus.vectorial = 1'b1; bus.lane_mask = 4'b0101;
        bus.wd = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
        tick();
        idle();
        #1;
        chk("masked_merge", bus.rd1, 128'h00000005_BBBBBBBB_00000007_DDDDDDDD);

        // Scalar write: lane 0 only, lane_mask ignored
        bus.we = 1'b1; bus.wa = 4'd3; bus.vectorial = 1'b0; bus.lane_mask = 4'b1010;
        bus.wd = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_0000000A;
        #1;
        chk("scalar_bypass", bus.rd1, 128'h00000005_BBBBBBBB_00000007_0000000A);
        tick();
        idle();
        #1;
        chk("scalar_merge", bus.rd1, 128'h00000005_BBBBBBBB_00000007_0000000A);

        // v0 is hard zero, even with a write to it in flight
        bus.ra1 = 4'd0;
        bus.we = 1'b1; bus.wa = 4'd0; bus.vectorial = 1'b1; bus.lane_mask = 4'b1111;
        bus.wd = {128{1'b1}};
        #1;
        chk("v0_bypass", bus.rd1, 128'h0);
        tick();
        idle();
        #1;
        chk("v0_after_write", bus.rd1, 128'h0);
        chk("v0_pending", {112'h0, bus.pending}, 128'h0);

        // Bypass into operand B
        bus.ra2 = 4'd5;
        bus.we = 1'b1; bus.wa = 4'd5; bus.vectorial = 1'b1; bus.lane_mask = 4'b1111;
        bus.wd = 128'h14;
        #1;
        chk("bypass_rd2", bus.rd2, 128'h14);
        tick();
        idle();
        #1;
        chk("stored_rd2", bus.rd2, 128'h14);

        // Hazard: issue to v4
        bus.ra1 = 4'd0; bus.ra2 = 4'd0;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd4;
        #1;
        chk("issue4_stall", {127'h0, bus.stall}, 128'h0);
        tick();
        idle();
        #1;
        chk("issue4_pending", {112'h0, bus.pending}, 128'h0010);

        // Consumer of v4 stalls; its destination v7 must not be marked
        bus.ra1 = 4'd4; bus.issue_valid = 1'b1; bus.issue_rd = 4'd7;
        #1;
        chk("raw_stall", {127'h0, bus.stall}, 128'h1);
        tick();
        #1;
        chk("stalled_pending_hold", {112'h0, bus.pending}, 128'h0010);
        chk("raw_stall_held", {127'h0, bus.stall}, 128'h1);

        // Writeback of v4 (no lanes written) releases the stall in the same cycle
        bus.we = 1'b1; bus.wa = 4'd4; bus.vectorial = 1'b1; bus.lane_mask = 4'b0000;
        bus.wd = {128{1'b1}};
        #1;
        chk("wb_release_stall", {127'h0, bus.stall}, 128'h0);
        chk("mask0_bypass_rd1", bus.rd1, 128'h0);
        tick();
        idle();
        #1;
        chk("wb_clear_issue7", {112'h0, bus.pending}, 128'h0080);
        chk("mask0_no_data", bus.rd1, 128'h0);

        // Set wins over clear on the same register
        bus.ra1 = 4'd0; bus.ra2 = 4'd0;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd6;
        bus.we = 1'b1; bus.wa = 4'd6; bus.vectorial = 1'b1; bus.lane_mask = 4'b1111;
        bus.wd = 128'h66;
        tick();
        idle();
        #1;
        chk("set_wins", {112'h0, bus.pending}, 128'h00C0);

        // Writeback v7 while issuing to v4 -> pending becomes 16'h0050
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd4;
        bus.we = 1'b1; bus.wa = 4'd7; bus.vectorial = 1'b0; bus.wd = 128'h77;
        tick();
        idle();
        #1;
        chk("pending_0050", {112'h0, bus.pending}, 128'h0050);

        // Mid-operation reset with a write and an issue presented
        rst = 1'b1;
        bus.we = 1'b1; bus.wa = 4'd3; bus.vectorial = 1'b1; bus.lane_mask = 4'b1111;
        bus.wd = 128'h1234;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd9;
        tick();
        rst = 1'b0;
        idle();
        bus.ra1 = 4'd3; bus.ra2 = 4'd6;
        #1;
        chk("rst_pending", {112'h0, bus.pending}, 128'h0);
        chk("rst_v3", bus.rd1, 128'h0);
        chk("rst_v6", bus.rd2, 128'h0);
        bus.ra1 = 4'd5; bus.ra2 = 4'd7;
        bus.issue_valid = 1'b1; bus.issue_rd = 4'd0;
        #1;
        chk("rst_v5", bus.rd1, 128'h0);
        chk("rst_v7", bus.rd2, 128'h0);
        chk("rst_stall", {127'h0, bus.stall}, 128'h0);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
